if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time, and
//  drives the IF/ID latch inputs PCAdd4/Inst/IFFlush directly. Handles stall from the hazard
//  unit, branch/jump redirect from ID, and variable-latency instruction memory.
//  Drives a NOP (32'h0) whenever no valid instruction is available.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INST   32'h0000_0000  encoding driven on Inst when no valid instruction
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hazard unit: hold current PC/instruction, issue no new request
//  branch_taken   in   1   ID resolved taken branch; target on branch_target
//  branch_target  in   32  branch destination
//  jump           in   1   ID decoded jump; target on jump_target
//  jump_target    in   32  jump destination
//  imem_req       out  1   request strobe; imem_addr valid while high
//  imem_addr      out  32  word-aligned fetch address
//  imem_ready     in   1   response valid this cycle (>=1 cycle after req)
//  imem_rdata     in   32  instruction word, valid with imem_ready
//  PCAdd4         out  32  fetch PC + 4, to IF/ID
//  Inst           out  32  fetched instruction or NOP_INST, to IF/ID
//  IFFlush        out  1   squash the instruction entering IF/ID this edge
// BEHAVIOUR
//  FSM states: BOOT, FETCH, WAIT, HOLD, DROP. Reset -> BOOT, pc=RESET_PC, imem_req=0,
//   Inst=NOP_INST, PCAdd4=RESET_PC+4, IFFlush=0, hold buffer invalid.
//  BOOT: one cycle, -> FETCH.
//  FETCH: imem_req=1, imem_addr=pc (comb); -> WAIT unless stall (stay FETCH, req=0).
//  WAIT: imem_req=0. On imem_ready & !stall: Inst=imem_rdata, PCAdd4=pc+4, pc<=pc+4, -> FETCH.
//   On imem_ready & stall: capture rdata in hold buffer, -> HOLD. No ready: Inst=NOP_INST.
//  HOLD: Inst=hold buffer, PCAdd4=pc+4; on !stall pc<=pc+4, buffer invalid, -> FETCH.
//  Redirect = branch_taken | jump; target = branch_taken ? branch_target : jump_target
//   (branch_taken wins if both). Redirect overrides stall.
//  On redirect: IFFlush=1 same cycle (comb); pc<=target; Inst forced NOP_INST.
//   From FETCH/HOLD/BOOT -> FETCH. From WAIT with imem_ready same cycle -> FETCH (response dropped).
//   From WAIT without imem_ready -> DROP. From DROP -> DROP (pc updated, newer target wins).
//  DROP: imem_req=0, Inst=NOP_INST; on imem_ready discard rdata, -> FETCH at current pc.
//  Single outstanding request at all times; imem_req never high in WAIT/DROP/HOLD.
//  PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Targets used as-is; bits[1:0] forced 0 on imem_addr.
//  rst mid-WAIT/DROP: return to BOOT; a late imem_ready after reset is ignored until first FETCH.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (instructions delivered non-NOP) and
//   perf_flushed[31:0] (redirect cycles); both clear on rst, wrap at 2^32, no other effect.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package/header: FSM state encodings (3-bit), NOP_INST, RESET_PC default.
//  One sub-module: if_next_pc (comb: pc+4, redirect select, target mux); FSM/regs in top.
// TESTING
//  Reset, imem_ready 1 cycle after req -> imem_addr 0,4,8 on successive FETCH; Inst matches rdata; PCAdd4 4,8,12.
//  imem_ready delayed 3 cycles -> Inst=0 for 3 cycles, no second req while waiting.
//  stall while response arrives -> HOLD; Inst held stable 4 cycles; on release next req addr=pc+4.
//  jump to 0x100 during WAIT, ready 2 cycles later -> IFFlush=1 one cycle, stale rdata dropped, next req 0x100.
//  branch_taken(0x40) & jump(0x80) same cycle, with stall=1 -> next req addr 0x40.
//  pc=0xFFFFFFFC fetch -> PCAdd4=0, next imem_addr=0; rst asserted in DROP -> BOOT, imem_req=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared FSM encodings and default constants for the fetch stage
package if_fetch_pkg;
   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DROP  = 3'd4
   } state_t;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: sequential PC increment and redirect target selection (branch wins over jump)
module if_next_pc (
   input  logic [31:0] pc,
   input  logic        advance,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] pc_add4,
   output logic        redirect,
   output logic [31:0] pc_next
);
   always_comb begin
      pc_add4  = pc + 32'd4;
      redirect = branch_taken | jump;
      pc_next  = branch_taken ? branch_target : jump ? jump_target : advance ? pc_add4 : pc;
   end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with single outstanding imem request, stall hold and redirect drop.
// Optional IF_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCAdd4,
   output logic [31:0] Inst,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
`endif
   output logic        IFFlush
);
   state_t      state, state_nx;
   logic [31:0] pc, pc_next, pc_add4, hold_buf;
   logic        redirect, advance;

   if_next_pc u_next_pc (
      .pc(pc),
      .advance(advance),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .jump(jump),
      .jump_target(jump_target),
      .pc_add4(pc_add4),
      .redirect(redirect),
      .pc_next(pc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_BOOT;
         pc       <= RESET_PC;
         hold_buf <= NOP_INST;
      end else begin
         state <= state_nx;
         pc    <= pc_next;
         if (state == ST_WAIT && imem_ready && stall && !redirect) hold_buf <= imem_rdata;
      end
   end

   // A redirect in WAIT with no response yet leaves one in flight, which DROP must absorb.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_BOOT:  state_nx = ST_FETCH;
         ST_FETCH: state_nx = (redirect || stall) ? ST_FETCH : ST_WAIT;
         ST_WAIT:  state_nx = redirect ? (imem_ready ? ST_FETCH : ST_DROP) :
                              imem_ready ? (stall ? ST_HOLD : ST_FETCH) : ST_WAIT;
         ST_HOLD:  state_nx = (redirect || !stall) ? ST_FETCH : ST_HOLD;
         ST_DROP:  state_nx = imem_ready ? ST_FETCH : ST_DROP;
         default:  state_nx = ST_BOOT;
      endcase
   end

   always_comb begin
      advance   = !stall && ((state == ST_WAIT && imem_ready) || state == ST_HOLD);
      imem_req  = state == ST_FETCH && !stall && !redirect;
      imem_addr = {pc[31:2], 2'b00};
      PCAdd4    = pc_add4;
      IFFlush   = redirect;
      Inst      = redirect ? NOP_INST :
                  (state == ST_WAIT && imem_ready) ? imem_rdata :
                  (state == ST_HOLD) ? hold_buf : NOP_INST;
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= 32'd0;
         perf_flushed <= 32'd0;
      end else begin
         if (advance && !redirect) perf_fetched <= perf_fetched + 32'd1;
         if (redirect) perf_flushed <= perf_flushed + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed stimulus with request/delivery scoreboard for if_fetch
module tb_if_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ready = 1'b0;
   logic [31:0] branch_target = 32'h0, jump_target = 32'h0, imem_rdata = 32'h0;
   logic        imem_req, IFFlush;
   logic [31:0] imem_addr, PCAdd4, Inst;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_flushed;
`endif
   int          errors = 0, checks = 0;
   logic [31:0] exp_addr[$];
   logic [63:0] exp_del[$];

   if_fetch dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .jump(jump),
      .jump_target(jump_target),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ready(imem_ready),
      .imem_rdata(imem_rdata),
      .PCAdd4(PCAdd4),
      .Inst(Inst),
`ifdef IF_PERF_CNT_EN
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed),
`endif
      .IFFlush(IFFlush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic st, input logic br, input logic jp,
                      input logic rdy, input logic [31:0] rd);
      @(posedge clk);
      #1;
      rst = r; stall = st; branch_taken = br; jump = jp; imem_ready = rdy; imem_rdata = rd;
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [31:0] ea;
      logic [63:0] ed;
      if (!rst) begin
         if (imem_req) begin
            if (exp_addr.size() == 0) chk("req_unexpected", imem_addr, 32'hxxxx_xxxx);
            else begin
               ea = exp_addr.pop_front();
               chk("req_addr", imem_addr, ea);
            end
         end
         if (!stall && Inst !== 32'h0) begin
            if (exp_del.size() == 0) chk("del_unexpected", Inst, 32'hxxxx_xxxx);
            else begin
               ed = exp_del.pop_front();
               chk("del_inst", Inst, ed[63:32]);
               chk("del_pcadd4", PCAdd4, ed[31:0]);
            end
         end
      end
   end

   initial begin
      exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h40,
                   32'hFFFF_FFFC, 32'h0, 32'h0};
      exp_del  = '{{32'hA000_0000, 32'h4}, {32'hA000_0001, 32'h8}, {32'hA000_0002, 32'hC},
                   {32'hB000_0000, 32'h10}, {32'hC000_0000, 32'h14},
                   {32'hF000_0000, 32'h0}, {32'h6000_0000, 32'h4}};
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_inst", Inst, 32'h0);
      chk("rst_pcadd4", PCAdd4, 32'h4);
      chk("rst_flush", {31'b0, IFFlush}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("boot_req", {31'b0, imem_req}, 32'd0);
      // back-to-back single-cycle-latency fetches
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hA000_0000);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hA000_0001);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hA000_0002);
      // three-cycle response latency
      cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk("wait_inst_nop", Inst, 32'h0);
      end
      cyc(0, 0, 0, 0, 1, 32'hB000_0000);
      // stall during response -> hold
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 32'hC000_0000);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 0, 0, 0, 32'h1234_5678);
         chk("hold_inst", Inst, 32'hC000_0000);
      end
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // jump during WAIT, stale response two cycles later
      jump_target = 32'h100;
      cyc(0, 0, 0, 1, 0, 0);
      chk("jmp_flush", {31'b0, IFFlush}, 32'd1);
      chk("jmp_inst", Inst, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("drop_flush", {31'b0, IFFlush}, 32'd0);
      cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("drop_inst", Inst, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      // branch and jump together under stall: branch wins
      branch_target = 32'h40; jump_target = 32'h80;
      cyc(0, 1, 1, 1, 0, 0);
      chk("bj_flush", {31'b0, IFFlush}, 32'd1);
      cyc(0, 0, 0, 0, 1, 32'hDEAD_0001);
      cyc(0, 0, 0, 0, 0, 0);
      // wrap at top of address space; redirect drops same-cycle response
      jump_target = 32'hFFFF_FFFC;
      cyc(0, 0, 0, 1, 1, 32'hDEAD_0002);
      chk("wrap_drop_inst", Inst, 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("wrap_pcadd4", PCAdd4, 32'h0);
      cyc(0, 0, 0, 0, 1, 32'hF000_0000);
      cyc(0, 0, 0, 0, 0, 0);
      // reset while in DROP; late ready ignored in BOOT
      jump_target = 32'h200;
      cyc(0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'hDEAD_0003);
      chk("post_rst_req", {31'b0, imem_req}, 32'd0);
      chk("post_rst_inst", Inst, 32'h0);
      chk("post_rst_pcadd4", PCAdd4, 32'h4);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h6000_0000);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
      chk("addr_q_left", exp_addr.size(), 32'd0);
      chk("del_q_left", exp_del.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
